pipeline_power_ctrl: RTL and testbench
======================================

Name: pipeline_power_ctrl

Overview:
Power-sequencing controller for the three-stage riscv_pipeline. It generates enable_fetch, enable_decode and enable_execute.
- Power-up is staggered front-to-back: fetch, then decode, then execute.
- Power-down is front-to-back with a drain window, so in-flight instructions complete before the downstream stages are gated.
- Power-down is triggered by an explicit request or by an idle-timeout.
- The block sits beside riscv_pipeline and drives its enable inputs directly.

Parameters:
- STAGE_DLY, 2, cycles between successive stage enable edges (legal range 1..255).
- DRAIN_DLY, 3, cycles fetch is off before decode is dropped (legal range 1..255).
- IDLE_LIMIT, 16, consecutive idle cycles in RUN before auto-sleep; 0 disables auto-sleep.
- CNT_W, 8, width of the delay and idle counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- wake_req  in  1  request pipeline power-up; level or pulse.
- sleep_req  in  1  request pipeline power-down; level or pulse.
- instr_valid  in  1  fetch-stage activity indicator; feeds the idle counter.
- enable_fetch  out  1  fetch stage enable (registered).
- enable_decode  out  1  decode stage enable (registered).
- enable_execute  out  1  execute stage enable (registered).
- ready  out  1  high only in RUN (all three stages enabled).
- asleep  out  1  high only in SLEEP (all three stages disabled).
- auto_sleep  out  1  one-cycle pulse when the idle-timeout starts a power-down.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset: reset=0 at a clock edge forces SLEEP.
  - All enables, ready and auto_sleep go to 0; asleep=1.
  - Counters and pending flags clear.
  - This applies mid-sequence too, abruptly; no drain.
- State encoding: SLEEP=0, WAKE_F=1, WAKE_D=2, RUN=3, DRAIN=4, OFF_D=5.
- All outputs are registered and change on the same edge as the state.
- Delay counter: loaded with (delay-1) on entry to each timed state, decrements each cycle, and the exit fires when it is 0.
- SLEEP:
  - wake_req (or pending wake) sampled at edge N goes to WAKE_F at N+1, with enable_fetch=1 and asleep=0.
  - sleep_req is ignored.
- WAKE_F: after STAGE_DLY cycles, go to WAKE_D with enable_decode=1.
- WAKE_D: after STAGE_DLY cycles, go to RUN with enable_execute=1 and ready=1.
- Wake timing: enable_fetch rises at N+1, enable_decode at N+1+STAGE_DLY, enable_execute at N+1+2*STAGE_DLY.
- RUN:
  - sleep_req (or pending sleep), or idle_cnt==IDLE_LIMIT with IDLE_LIMIT≠0, goes to DRAIN.
  - On entering DRAIN: enable_fetch=0 and ready=0.
  - auto_sleep pulses only when the idle-timeout is the cause, not on an explicit or pending sleep request.
  - If sleep and timeout coincide, the request wins and there is no pulse.
  - wake_req is ignored.
- DRAIN: after DRAIN_DLY cycles, go to OFF_D with enable_decode=0.
- OFF_D: after STAGE_DLY cycles, go to SLEEP with enable_execute=0 and asleep=1.
- Idle counter:
  - Active only in RUN; cleared on RUN entry and on any cycle with instr_valid=1.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - The timeout triggers on the cycle the counter equals IDLE_LIMIT.
- Requests during transitional states (WAKE_F, WAKE_D, DRAIN, OFF_D) are latched as pending flags:
  - sleep_req sets pend_sleep and clears pend_wake; wake_req sets pend_wake and clears pend_sleep.
  - If both arrive in the same cycle: in WAKE_* pend_sleep wins, in DRAIN/OFF_D pend_wake wins.
  - A sequence in progress is never aborted; the pending flag is consumed at the next stable state (RUN or SLEEP).
  - The flag is cleared on the cycle it triggers the transition.
  - Consequence: RUN and SLEEP can each last a single cycle.
- Invariants, checked by assertions:
  - enable_execute ⇒ enable_decode, except during OFF_D.
  - enable_decode ⇒ enable_fetch, except during DRAIN and OFF_D.
  - ready and asleep are never both high.

Decomposition:
- Shared package pwr_pkg holds the state enum (3-bit constants above) and default parameter constants.
- One sub-module, pwr_delay_counter: loadable down-counter with zero flag, parameterised by CNT_W.
- The idle counter is inline.

Test Plan:
- Reset with wake_req=0 for 3 cycles: all enables 0, asleep=1, state=0.
- Wake: wake_req pulse at edge 10 with defaults → enable_fetch=1 @11, enable_decode=1 @13, enable_execute=1 and ready=1 @15.
- Explicit sleep: in RUN, sleep_req at edge 20 → enable_fetch=0 @21, enable_decode=0 @24, enable_execute=0 @26, asleep=1 @26, auto_sleep stays 0.
- Idle timeout: RUN entered @15 with instr_valid=0 throughout → auto_sleep pulse and DRAIN @31. Repeat with an instr_valid pulse @25 → DRAIN delayed to @42.
- Pending requests:
  - sleep_req during WAKE_F → RUN lasts exactly 1 cycle, then DRAIN.
  - wake_req during DRAIN → SLEEP lasts 1 cycle, then WAKE_F.
- Reset mid-WAKE_D (reset=0 @13) → all enables 0 and state=SLEEP @14; no pending flag survives.

Source files
------------

// File: rtl/pwr_pkg.sv
// Shared types and defaults for the pipeline power-sequencing controller.
package pwr_pkg;

    typedef enum logic [2:0] {
        SLEEP  = 3'd0,
        WAKE_F = 3'd1,
        WAKE_D = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        OFF_D  = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
    } stage_en_t;

    localparam int DEF_STAGE_DLY  = 2;
    localparam int DEF_DRAIN_DLY  = 3;
    localparam int DEF_IDLE_LIMIT = 16;
    localparam int DEF_CNT_W      = 8;

    // Which pipeline stages are powered while the controller sits in a given state.
    function automatic stage_en_t stage_enables(pwr_state_e s);
        stage_en_t en;
        en.fetch   = (s == WAKE_F) || (s == WAKE_D) || (s == RUN);
        en.decode  = (s == WAKE_D) || (s == RUN)    || (s == DRAIN);
        en.execute = (s == RUN)    || (s == DRAIN)  || (s == OFF_D);
        return en;
    endfunction

endpackage

// File: rtl/pwr_delay_counter.sv
// Loadable down-counter with a zero flag; times the dwell in each transitional state.
module pwr_delay_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipeline_power_ctrl.sv
// Power sequencer for the three-stage pipeline: staggered wake, drained sleep, idle auto-sleep.
module pipeline_power_ctrl
    import pwr_pkg::*;
#(
    parameter int STAGE_DLY  = DEF_STAGE_DLY,
    parameter int DRAIN_DLY  = DEF_DRAIN_DLY,
    parameter int IDLE_LIMIT = DEF_IDLE_LIMIT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wake_req,
    input  logic       sleep_req,
    input  logic       instr_valid,
    output logic       enable_fetch,
    output logic       enable_decode,
    output logic       enable_execute,
    output logic       ready,
    output logic       asleep,
    output logic       auto_sleep,
    output logic [2:0] state
);

    pwr_state_e       state_q, state_d;
    logic             pend_wake_q, pend_wake_d;
    logic             pend_sleep_q, pend_sleep_d;
    logic             auto_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_step;
    logic             timeout;
    logic             dly_load, dly_zero;
    logic [CNT_W-1:0] dly_val;
    stage_en_t        en_d;

    pwr_delay_counter #(.CNT_W(CNT_W)) u_dly (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    // Idle count this cycle would end with; the timeout fires on the edge it reaches the limit.
    assign idle_step = instr_valid ? '0 :
                       (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
    assign timeout   = (IDLE_LIMIT != 0) && (int'(idle_step) == IDLE_LIMIT);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        pend_wake_d  = pend_wake_q;
        pend_sleep_d = pend_sleep_q;
        auto_d       = 1'b0;
        unique case (state_q)
            SLEEP: begin
                pend_wake_d  = 1'b0;
                pend_sleep_d = 1'b0;
                if (wake_req || pend_wake_q) state_d = WAKE_F;
            end
            RUN: begin
                pend_wake_d  = 1'b0;
                pend_sleep_d = 1'b0;
                if (sleep_req || pend_sleep_q) begin
                    state_d = DRAIN;
                end else if (timeout) begin
                    state_d = DRAIN;
                    auto_d  = 1'b1;
                end
            end
            WAKE_F, WAKE_D: begin
                // Sleep is applied last so it wins a same-cycle collision while waking.
                if (wake_req)  {pend_wake_d, pend_sleep_d} = 2'b10;
                if (sleep_req) {pend_wake_d, pend_sleep_d} = 2'b01;
                if (dly_zero)  state_d = (state_q == WAKE_F) ? WAKE_D : RUN;
            end
            DRAIN, OFF_D: begin
                if (sleep_req) {pend_wake_d, pend_sleep_d} = 2'b01;
                if (wake_req)  {pend_wake_d, pend_sleep_d} = 2'b10;
                if (dly_zero)  state_d = (state_q == DRAIN) ? OFF_D : SLEEP;
            end
            default: state_d = SLEEP;
        endcase
    end

    assign dly_load = (state_d != state_q) && (state_d != SLEEP) && (state_d != RUN);
    assign dly_val  = (state_d == DRAIN) ? CNT_W'(DRAIN_DLY - 1) : CNT_W'(STAGE_DLY - 1);
    assign en_d     = stage_enables(state_d);

    // Outputs are decoded from the next state so they move on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= SLEEP;
            pend_wake_q    <= 1'b0;
            pend_sleep_q   <= 1'b0;
            idle_cnt_q     <= '0;
            enable_fetch   <= 1'b0;
            enable_decode  <= 1'b0;
            enable_execute <= 1'b0;
            ready          <= 1'b0;
            asleep         <= 1'b1;
            auto_sleep     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_wake_q    <= pend_wake_d;
            pend_sleep_q   <= pend_sleep_d;
            idle_cnt_q     <= (state_q == RUN && state_d == RUN) ? idle_step : '0;
            enable_fetch   <= en_d.fetch;
            enable_decode  <= en_d.decode;
            enable_execute <= en_d.execute;
            ready          <= (state_d == RUN);
            asleep         <= (state_d == SLEEP);
            auto_sleep     <= auto_d;
        end
    end

    assign state = state_q;

    a_exec_needs_decode: assert property (@(posedge clk) disable iff (!reset)
        (enable_execute && state_q != OFF_D) |-> enable_decode);
    a_decode_needs_fetch: assert property (@(posedge clk) disable iff (!reset)
        (enable_decode && state_q != DRAIN && state_q != OFF_D) |-> enable_fetch);
    a_ready_asleep_excl: assert property (@(posedge clk) disable iff (!reset)
        !(ready && asleep));

endmodule

// File: tb/tb_pipeline_power_ctrl.sv
// Directed bench for pipeline_power_ctrl: an absolute-time schedule model checked every cycle plus pinned literals.
module tb_pipeline_power_ctrl;

    localparam int STAGE = 2;
    localparam int DRAIN = 3;
    localparam int IDLE  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wake_req = 1'b0, sleep_req = 1'b0, instr_valid = 1'b0;
    logic       enable_fetch, enable_decode, enable_execute, ready, asleep, auto_sleep;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;

    pipeline_power_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .wake_req       (wake_req),
        .sleep_req      (sleep_req),
        .instr_valid    (instr_valid),
        .enable_fetch   (enable_fetch),
        .enable_decode  (enable_decode),
        .enable_execute (enable_execute),
        .ready          (ready),
        .asleep         (asleep),
        .auto_sleep     (auto_sleep),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: phase code (0 sleep .. 5 off_d), absolute edge at which the current phase ends,
    // the edge of the last fetch activity, and the two pending request flags.
    int m_ph = 0, m_due = 0, m_anchor = 0, m_idle = 0;
    bit m_pw = 0, m_ps = 0, m_auto = 0, m_valid = 0;

    always @(posedge clk) begin
        cyc++;
        m_auto = 0;
        if (!reset) begin
            m_ph = 0; m_pw = 0; m_ps = 0; m_valid = 1;
        end else if (m_ph == 0) begin
            if (wake_req || m_pw) begin m_ph = 1; m_due = cyc + STAGE; end
            m_pw = 0; m_ps = 0;
        end else if (m_ph == 3) begin
            if (instr_valid) m_anchor = cyc;
            m_idle = cyc - m_anchor;
            if (m_idle > 255) m_idle = 255;
            if (sleep_req || m_ps) begin
                m_ph = 4; m_due = cyc + DRAIN;
            end else if (IDLE != 0 && m_idle == IDLE) begin
                m_ph = 4; m_due = cyc + DRAIN; m_auto = 1;
            end
            m_pw = 0; m_ps = 0;
        end else begin
            if (m_ph <= 2) begin
                if (wake_req)  begin m_pw = 1; m_ps = 0; end
                if (sleep_req) begin m_ps = 1; m_pw = 0; end
            end else begin
                if (sleep_req) begin m_ps = 1; m_pw = 0; end
                if (wake_req)  begin m_pw = 1; m_ps = 0; end
            end
            if (cyc == m_due) begin
                case (m_ph)
                    1: begin m_ph = 2; m_due = cyc + STAGE; end
                    2: begin m_ph = 3; m_anchor = cyc; end
                    4: begin m_ph = 5; m_due = cyc + STAGE; end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [8:0] act, exp;
            act = {state, enable_fetch, enable_decode, enable_execute, ready, asleep, auto_sleep};
            exp = {3'(m_ph), m_ph inside {1, 2, 3}, m_ph inside {2, 3, 4}, m_ph inside {3, 4, 5},
                   m_ph == 3, m_ph == 0, m_auto};
            check($sformatf("outputs@%0d", cyc - base), 32'(act), 32'(exp));
        end
    end

    // Advance to 1 time unit after relative edge k (outputs of edge k are then settled).
    task automatic goto(input int k);
        while (cyc - base < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        reset = 1'b0; wake_req = 1'b0; sleep_req = 1'b0; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base  = cyc;
        reset = 1'b1;
    endtask

    task automatic pulse_wake(input int k);
        goto(k); wake_req = 1'b1; goto(k + 1); wake_req = 1'b0;
    endtask

    task automatic pulse_sleep(input int k);
        goto(k); sleep_req = 1'b1; goto(k + 1); sleep_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, staggered wake and explicit drained sleep.
        restart();
        check("reset_state", state, 0);
        check("reset_asleep", asleep, 1);
        check("reset_enables", {enable_fetch, enable_decode, enable_execute}, 0);
        pulse_wake(10);
        check("fetch@11", enable_fetch, 1);
        goto(12); check("decode@12", enable_decode, 0);
        goto(13); check("decode@13", enable_decode, 1);
        goto(14); check("execute@14", enable_execute, 0);
        goto(15); check("execute@15", enable_execute, 1);
        check("ready@15", ready, 1);
        pulse_wake(17);
        pulse_sleep(20);
        check("fetch_off@21", enable_fetch, 0);
        check("ready_off@21", ready, 0);
        goto(23); check("decode@23", enable_decode, 1);
        goto(24); check("decode_off@24", enable_decode, 0);
        goto(25); check("execute@25", enable_execute, 1);
        goto(26); check("execute_off@26", enable_execute, 0);
        check("asleep@26", asleep, 1);

        // Idle timeout with no fetch activity.
        restart();
        pulse_wake(10);
        goto(30); check("idle_run@30", state, 3);
        goto(31); check("idle_drain@31", state, 4);
        check("auto_sleep@31", auto_sleep, 1);
        check("model_phase@31", 32'(m_ph), 4);
        goto(32); check("auto_sleep@32", auto_sleep, 0);

        // Idle timeout pushed out by one active fetch cycle.
        restart();
        pulse_wake(10);
        goto(25); instr_valid = 1'b1; goto(26); instr_valid = 1'b0;
        goto(41); check("idle2_run@41", state, 3);
        goto(42); check("idle2_drain@42", state, 4);
        check("auto_sleep2@42", auto_sleep, 1);

        // Pending requests across transitional states, including same-cycle collisions.
        restart();
        pulse_wake(10);
        pulse_sleep(12);
        goto(15); check("pend_run@15", state, 3);
        goto(16); check("pend_drain@16", state, 4);
        check("pend_no_auto@16", auto_sleep, 0);
        pulse_wake(18);
        goto(21); check("pend_sleep@21", state, 0);
        goto(22); check("pend_wakef@22", state, 1);
        goto(23); wake_req = 1'b1; sleep_req = 1'b1;
        goto(24); wake_req = 1'b0; sleep_req = 1'b0;
        goto(26); check("both_run@26", state, 3);
        goto(27); check("both_drain@27", state, 4);
        check("model_phase@27", 32'(m_ph), 4);
        goto(28); wake_req = 1'b1; sleep_req = 1'b1;
        goto(29); wake_req = 1'b0; sleep_req = 1'b0;
        goto(32); check("both_sleep@32", state, 0);
        goto(33); check("both_wakef@33", state, 1);

        // Abrupt reset in WAKE_D with a pending wake that must not survive.
        restart();
        pulse_wake(10);
        pulse_wake(12);
        goto(13); check("wake_d@13", state, 2);
        reset = 1'b0;
        goto(14); reset = 1'b1;
        check("midreset_state@14", state, 0);
        check("midreset_enables@14", {enable_fetch, enable_decode, enable_execute}, 0);
        check("midreset_asleep@14", asleep, 1);
        goto(16); check("no_pending@16", state, 0);
        pulse_sleep(17);
        goto(19); check("sleep_ignored@19", state, 0);

        goto(22);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
